adc_dac_bridge: RTL and testbench
=================================

Name: adc_dac_bridge

Overview:
- Parametrised, multi-channel ADC-to-DAC sample path for the AD9238/AN9767 front end.
- Sits between the ADC capture block and the DDR-output DAC driver, all in the sys_clk domain.
- Adds input format conversion, per-channel digital gain with saturation, and per-channel source select (loopback, ramp, DC, mute).
- Also keeps per-channel min/max statistics and sticky saturation flags.

Parameters:
ADC_W, 12, ADC sample width; must satisfy ADC_W <= DAC_W
DAC_W, 14, DAC word width
NCH, 2, number of channels
GAIN_W, 3, width of per-channel left-shift gain (0..2^GAIN_W-1)
OUT_OFFSET_BIN, 1, 1 = DAC words are offset binary (MSB inverted); 0 = two's complement

Ports:
sys_clk  in  1  system clock
rst_n  in  1  reset, synchronous, active-low
sample_ce  in  1  adc_data valid this cycle
adc_data  in  NCH*ADC_W  ADC samples, ch0 in LSBs
in_twos_comp  in  1  1 = adc_data two's complement, 0 = offset binary
mode  in  2*NCH  per-channel source: 00 loopback, 01 ramp, 10 DC, 11 mute
gain_shift  in  GAIN_W*NCH  per-channel left shift
dc_value  in  DAC_W*NCH  per-channel signed DC level
ramp_step  in  DAC_W  shared ramp increment (unsigned)
stat_clr  in  1  clear statistics and saturation flags
dac_data  out  NCH*DAC_W  DAC words, held between valids
dac_valid  out  1  dac_data updated this cycle
peak_max  out  NCH*ADC_W  signed running maximum per channel
peak_min  out  NCH*ADC_W  signed running minimum per channel
sat_flag  out  NCH  sticky per-channel saturation flag

Behaviour:
- Clock and reset: one clock, sys_clk. rst_n is synchronous, active-low.
- Reset values:
  - dac_data = signed 0 in output format (14'h2000 per channel when OUT_OFFSET_BIN=1).
  - dac_valid = 0; pipeline valids = 0; ramp accumulators = 0; sat_flag = 0.
  - peak_max = -2^(ADC_W-1); peak_min = 2^(ADC_W-1)-1.
- Pipeline: free-running, with a valid bit per stage. Latency is fixed at 3 cycles: sample_ce in cycle N gives dac_valid=1 in cycle N+3. Throughput is one sample per cycle.
- S1 (convert): register adc_data; if in_twos_comp=0, invert the MSB. Result is a signed ADC_W value.
- S2 (gain and select), per channel:
  - Sign-extend, then left-align: shift left by (DAC_W-ADC_W), then by gain_shift.
  - Saturate to the signed DAC_W range [-2^(DAC_W-1), 2^(DAC_W-1)-1].
  - A sample saturates only if the shifted value falls outside that range; this sets sat_flag for loopback mode only.
  - mode selects the S2 result:
    - 00: the gained sample.
    - 01: ramp accumulator value. The accumulator then adds ramp_step, modulo 2^DAC_W (wraps, never saturates). It is forced to 0 whenever mode != 01.
    - 10: dc_value.
    - 11: 0.
  - mode, gain_shift and dc_value are sampled only when the S2 input is valid.
- S3 (output): if OUT_OFFSET_BIN=1, invert the MSB; register into dac_data; dac_valid = S2 valid.
- Statistics: updated from the S1 signed value when S1 is valid, in every mode.
  - stat_clr with no valid sample: restore the reset values.
  - stat_clr together with a valid sample: peak_max = peak_min = that sample.
  - sat_flag, same cycle clear and set: set wins.
- Reset mid-stream: all in-flight samples are dropped, and no dac_valid appears before the 3rd cycle after the first post-reset sample_ce.
- Gaps in sample_ce: bubbles propagate and dac_data holds its last value.

Test Plan (defaults; ch0 shown, ch1 driven identically unless noted):
1. Loopback, two's complement, shift 0: adc 12'h7FF -> dac_data 14'h3FFC; adc 12'h800 -> 14'h0000. Each appears exactly 3 cycles after sample_ce with dac_valid=1.
2. Offset-binary input (in_twos_comp=0): adc 12'h800 -> 14'h2000; adc 12'hFFF -> 14'h3FFC.
3. Gain saturation, shift 2:
   - adc 12'h400 (+1024) -> 14'h3FFF, sat_flag[0]=1.
   - adc 12'hC00 (-1024) -> 14'h0000.
   - ch1 with shift 0 -> sat_flag[1]=0.
   - Then stat_clr -> sat_flag=0.
4. Ramp: mode=01, ramp_step=100, continuous ce:
   - Outputs 14'h2000, 14'h2064, 14'h20C8, 14'h212C.
   - After 164 samples the accumulator wraps to 16.
   - Switching to mode 11 gives 14'h2000; returning to 01 restarts at 0.
5. Statistics: samples +5, -3, +100, -200 -> peak_max=100, peak_min=-200. Then stat_clr with a valid sample of +7 in the same cycle -> peak_max=peak_min=7.
6. Reset mid-stream: continuous ce, rst_n low 1 cycle -> next cycle dac_data=14'h2000 and dac_valid=0. dac_valid reasserts exactly 3 cycles after the first post-reset ce; the DC mode value 14'h1000 (signed 4096) -> 14'h3000.

Source files
------------

// File: rtl/adc_dac_bridge_if.sv
// Sample-path bundle between the ADC capture block, the bridge and the DAC driver.
// The bridge takes the slave side: it consumes ADC samples and produces DAC words.
interface adc_dac_bridge_if #(
  parameter int ADC_W = 12,
  parameter int DAC_W = 14,
  parameter int NCH   = 2
);
  logic                 sample_ce;
  logic [NCH*ADC_W-1:0] adc_data;
  logic                 dac_valid;
  logic [NCH*DAC_W-1:0] dac_data;

  modport master (
    output sample_ce,
    output adc_data,
    input  dac_valid,
    input  dac_data
  );

  modport slave (
    input  sample_ce,
    input  adc_data,
    output dac_valid,
    output dac_data
  );
endinterface

// File: rtl/adc_dac_bridge.sv
// Three-stage ADC-to-DAC sample path: format convert, per-channel gain/saturate/source
// select, output format. Also keeps per-channel peak statistics and sticky saturation flags.
module adc_dac_bridge #(
  parameter int ADC_W          = 12,
  parameter int DAC_W          = 14,
  parameter int NCH            = 2,
  parameter int GAIN_W         = 3,
  parameter bit OUT_OFFSET_BIN = 1'b1
) (
  input  logic                  sys_clk,
  input  logic                  rst_n,
  adc_dac_bridge_if.slave       bus,
  input  logic                  in_twos_comp,
  input  logic [2*NCH-1:0]      mode,
  input  logic [GAIN_W*NCH-1:0] gain_shift,
  input  logic [DAC_W*NCH-1:0]  dc_value,
  input  logic [DAC_W-1:0]      ramp_step,
  input  logic                  stat_clr,
  output logic [NCH*ADC_W-1:0]  peak_max,
  output logic [NCH*ADC_W-1:0]  peak_min,
  output logic [NCH-1:0]        sat_flag
);

  localparam int LSH  = DAC_W - ADC_W;
  // Wide enough to hold the largest left shift without losing the sign.
  localparam int WIDE = DAC_W + (2**GAIN_W) - 1;

  localparam logic signed [WIDE-1:0]  SAT_HI   = WIDE'((2**(DAC_W-1)) - 1);
  localparam logic signed [WIDE-1:0]  SAT_LO   = ~SAT_HI;
  localparam logic [DAC_W-1:0]        DAC_MAX  = {1'b0, {(DAC_W-1){1'b1}}};
  localparam logic [DAC_W-1:0]        DAC_MIN  = {1'b1, {(DAC_W-1){1'b0}}};
  localparam logic [DAC_W-1:0]        OUT_FLIP = OUT_OFFSET_BIN ? DAC_MIN : '0;
  localparam logic signed [ADC_W-1:0] ADC_MAX  = {1'b0, {(ADC_W-1){1'b1}}};
  localparam logic signed [ADC_W-1:0] ADC_MIN  = {1'b1, {(ADC_W-1){1'b0}}};

  typedef enum logic [1:0] {
    SRC_LOOP = 2'b00,
    SRC_RAMP = 2'b01,
    SRC_DC   = 2'b10,
    SRC_MUTE = 2'b11
  } src_e;

  logic                    s1_valid_q, s1_valid_d;
  logic signed [ADC_W-1:0] s1_data_q [NCH];
  logic signed [ADC_W-1:0] s1_data_d [NCH];
  logic                    s2_valid_q, s2_valid_d;
  logic [DAC_W-1:0]        s2_data_q [NCH];
  logic [DAC_W-1:0]        s2_data_d [NCH];
  logic                    dac_valid_q, dac_valid_d;
  logic [NCH*DAC_W-1:0]    dac_data_q, dac_data_d;
  logic [DAC_W-1:0]        ramp_q [NCH];
  logic [DAC_W-1:0]        ramp_d [NCH];
  logic signed [ADC_W-1:0] max_q [NCH];
  logic signed [ADC_W-1:0] max_d [NCH];
  logic signed [ADC_W-1:0] min_q [NCH];
  logic signed [ADC_W-1:0] min_d [NCH];
  logic [NCH-1:0]          sat_q, sat_d;

  logic [ADC_W-1:0]        in_flip;
  logic signed [WIDE-1:0]  ext [NCH];
  logic signed [WIDE-1:0]  shifted [NCH];
  logic [DAC_W-1:0]        gained [NCH];
  logic [NCH-1:0]          sat_hit;

  assign in_flip = {~in_twos_comp, {(ADC_W-1){1'b0}}};

  // S1: capture and convert to signed
  always_comb begin
    s1_valid_d = bus.sample_ce;
    s1_data_d  = s1_data_q;
    if (bus.sample_ce) begin
      for (int ch = 0; ch < NCH; ch++) begin
        s1_data_d[ch] = bus.adc_data[ch*ADC_W +: ADC_W] ^ in_flip;
      end
    end
  end

  // Gain path: sign-extend, left-align into the DAC word, apply gain, clamp
  always_comb begin
    for (int ch = 0; ch < NCH; ch++) begin
      ext[ch]     = {{(WIDE-ADC_W){s1_data_q[ch][ADC_W-1]}}, s1_data_q[ch]};
      shifted[ch] = ext[ch] << (LSH + int'(gain_shift[ch*GAIN_W +: GAIN_W]));
      sat_hit[ch] = 1'b0;
      gained[ch]  = shifted[ch][DAC_W-1:0];
      if (shifted[ch] > SAT_HI) begin
        gained[ch]  = DAC_MAX;
        sat_hit[ch] = 1'b1;
      end else if (shifted[ch] < SAT_LO) begin
        gained[ch]  = DAC_MIN;
        sat_hit[ch] = 1'b1;
      end
    end
  end

  // S2: source select, ramp generators, saturation flags
  always_comb begin
    s2_valid_d = s1_valid_q;
    s2_data_d  = s2_data_q;
    ramp_d     = ramp_q;
    sat_d      = sat_q;
    if (stat_clr) begin
      sat_d = '0;
    end
    for (int ch = 0; ch < NCH; ch++) begin
      if (src_e'(mode[2*ch +: 2]) != SRC_RAMP) begin
        ramp_d[ch] = '0;
      end
      if (s1_valid_q) begin
        case (src_e'(mode[2*ch +: 2]))
          SRC_LOOP: begin
            s2_data_d[ch] = gained[ch];
            if (sat_hit[ch]) begin
              sat_d[ch] = 1'b1;
            end
          end
          SRC_RAMP: begin
            s2_data_d[ch] = ramp_q[ch];
            ramp_d[ch]    = ramp_q[ch] + ramp_step;
          end
          SRC_DC:   s2_data_d[ch] = dc_value[ch*DAC_W +: DAC_W];
          SRC_MUTE: s2_data_d[ch] = '0;
          default:  s2_data_d[ch] = '0;
        endcase
      end
    end
  end

  // S3: output format; dac_data holds between valids
  always_comb begin
    dac_valid_d = s2_valid_q;
    dac_data_d  = dac_data_q;
    if (s2_valid_q) begin
      for (int ch = 0; ch < NCH; ch++) begin
        dac_data_d[ch*DAC_W +: DAC_W] = s2_data_q[ch] ^ OUT_FLIP;
      end
    end
  end

  // Peak statistics track the converted input regardless of the selected source
  always_comb begin
    max_d = max_q;
    min_d = min_q;
    for (int ch = 0; ch < NCH; ch++) begin
      if (s1_valid_q) begin
        if (stat_clr) begin
          max_d[ch] = s1_data_q[ch];
          min_d[ch] = s1_data_q[ch];
        end else begin
          if (s1_data_q[ch] > max_q[ch]) max_d[ch] = s1_data_q[ch];
          if (s1_data_q[ch] < min_q[ch]) min_d[ch] = s1_data_q[ch];
        end
      end else if (stat_clr) begin
        max_d[ch] = ADC_MIN;
        min_d[ch] = ADC_MAX;
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s2_valid_q  <= 1'b0;
      dac_valid_q <= 1'b0;
      sat_q       <= '0;
      for (int ch = 0; ch < NCH; ch++) begin
        s1_data_q[ch]                 <= '0;
        s2_data_q[ch]                 <= '0;
        ramp_q[ch]                    <= '0;
        max_q[ch]                     <= ADC_MIN;
        min_q[ch]                     <= ADC_MAX;
        dac_data_q[ch*DAC_W +: DAC_W] <= OUT_FLIP;
      end
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_data_q   <= s1_data_d;
      s2_valid_q  <= s2_valid_d;
      s2_data_q   <= s2_data_d;
      dac_valid_q <= dac_valid_d;
      dac_data_q  <= dac_data_d;
      ramp_q      <= ramp_d;
      max_q       <= max_d;
      min_q       <= min_d;
      sat_q       <= sat_d;
    end
  end

  assign bus.dac_valid = dac_valid_q;
  assign bus.dac_data  = dac_data_q;
  assign sat_flag      = sat_q;

  always_comb begin
    peak_max = '0;
    peak_min = '0;
    for (int ch = 0; ch < NCH; ch++) begin
      peak_max[ch*ADC_W +: ADC_W] = max_q[ch];
      peak_min[ch*ADC_W +: ADC_W] = min_q[ch];
    end
  end

endmodule

// File: tb/tb_adc_dac_bridge.sv
// Scoreboard bench for adc_dac_bridge: stimulus pushes expected DAC words with issue cycle,
// a negedge monitor pops and checks data and the fixed 3-cycle latency.
module tb_adc_dac_bridge;
  localparam int ADC_W  = 12;
  localparam int DAC_W  = 14;
  localparam int NCH    = 2;
  localparam int GAIN_W = 3;

  logic sys_clk = 1'b0;
  logic rst_n;
  always #5 sys_clk = ~sys_clk;

  adc_dac_bridge_if #(.ADC_W(ADC_W), .DAC_W(DAC_W), .NCH(NCH)) bus ();

  logic                  in_twos_comp;
  logic [2*NCH-1:0]      mode;
  logic [GAIN_W*NCH-1:0] gain_shift;
  logic [DAC_W*NCH-1:0]  dc_value;
  logic [DAC_W-1:0]      ramp_step;
  logic                  stat_clr;
  logic [NCH*ADC_W-1:0]  peak_max;
  logic [NCH*ADC_W-1:0]  peak_min;
  logic [NCH-1:0]        sat_flag;

  adc_dac_bridge #(
    .ADC_W(ADC_W), .DAC_W(DAC_W), .NCH(NCH), .GAIN_W(GAIN_W), .OUT_OFFSET_BIN(1'b1)
  ) dut (
    .sys_clk      (sys_clk),
    .rst_n        (rst_n),
    .bus          (bus),
    .in_twos_comp (in_twos_comp),
    .mode         (mode),
    .gain_shift   (gain_shift),
    .dc_value     (dc_value),
    .ramp_step    (ramp_step),
    .stat_clr     (stat_clr),
    .peak_max     (peak_max),
    .peak_min     (peak_min),
    .sat_flag     (sat_flag)
  );

  typedef struct {
    logic [NCH*DAC_W-1:0] data;
    int                   cyc;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;

  always @(posedge sys_clk) cyc++;

  // Monitor: every dac_valid must match the oldest outstanding expectation
  always @(negedge sys_clk) begin
    if (bus.dac_valid === 1'b1) begin
      if (q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_valid cyc=%0d got=%h expected no valid", cyc, bus.dac_data);
      end else begin
        e = q.pop_front();
        n_tests++;
        if (bus.dac_data !== e.data) begin
          n_fail++;
          $display("FAIL dac_data cyc=%0d got=%h expected=%h", cyc, bus.dac_data, e.data);
        end
        n_tests++;
        if (cyc != e.cyc + 3) begin
          n_fail++;
          $display("FAIL latency issued=%0d got_cyc=%0d expected_cyc=%0d", e.cyc, cyc, e.cyc + 3);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_tests++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s got=%h expected=%h", name, act, want);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  // One sample on both channels; caller is positioned 1 time unit after a posedge
  task automatic issue(input logic [ADC_W-1:0] a0, input logic [ADC_W-1:0] a1,
                       input logic [DAC_W-1:0] x0, input logic [DAC_W-1:0] x1);
    exp_t t;
    bus.sample_ce = 1'b1;
    bus.adc_data  = {a1, a0};
    t.data = {x1, x0};
    t.cyc  = cyc;
    q.push_back(t);
    @(posedge sys_clk);
    #1;
    bus.sample_ce = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && q.size() != 0; i++) idle(1);
    check("drain_empty", q.size(), 0);
    idle(1);
  endtask

  logic [DAC_W-1:0] r;

  initial begin
    rst_n         = 1'b0;
    bus.sample_ce = 1'b0;
    bus.adc_data  = '0;
    in_twos_comp  = 1'b1;
    mode          = '0;
    gain_shift    = '0;
    dc_value      = '0;
    ramp_step     = '0;
    stat_clr      = 1'b0;
    idle(2);

    check("rst_dac_data", bus.dac_data, {14'h2000, 14'h2000});
    check("rst_dac_valid", bus.dac_valid, 0);
    check("rst_peak_max", peak_max, {12'h800, 12'h800});
    check("rst_peak_min", peak_min, {12'h7FF, 12'h7FF});
    check("rst_sat_flag", sat_flag, 0);
    rst_n = 1'b1;
    idle(1);

    // Loopback, two's complement, no gain
    issue(12'h7FF, 12'h7FF, 14'h3FFC, 14'h3FFC);
    issue(12'h800, 12'h800, 14'h0000, 14'h0000);
    drain();

    // Offset-binary input
    in_twos_comp = 1'b0;
    issue(12'h800, 12'h800, 14'h2000, 14'h2000);
    issue(12'hFFF, 12'hFFF, 14'h3FFC, 14'h3FFC);
    drain();
    in_twos_comp = 1'b1;

    // Gain saturation: ch0 shift 2, ch1 shift 0
    gain_shift = {3'd0, 3'd2};
    issue(12'h400, 12'h400, 14'h3FFF, 14'h3000);
    issue(12'hC00, 12'hC00, 14'h0000, 14'h1000);
    drain();
    check("sat_flag_set", sat_flag, 2'b01);
    stat_clr = 1'b1;
    idle(1);
    stat_clr = 1'b0;
    check("sat_flag_clr", sat_flag, 0);
    check("stat_clr_peak_max", peak_max, {12'h800, 12'h800});
    check("stat_clr_peak_min", peak_min, {12'h7FF, 12'h7FF});
    // Exactly at the range limits: no saturation
    issue(12'h1FF, 12'h000, 14'h3FF0, 14'h2000);
    issue(12'hE00, 12'h000, 14'h0000, 14'h2000);
    drain();
    check("sat_flag_boundary", sat_flag, 0);
    gain_shift = '0;

    // Ramp with continuous sample_ce, wrapping modulo 2^14
    mode      = 4'b0101;
    ramp_step = 14'd100;
    idle(2);
    for (int k = 0; k < 170; k++) begin
      r = DAC_W'(k * 100) ^ 14'h2000;
      issue(12'h000, 12'h000, r, r);
    end
    drain();
    mode = 4'b1111;
    idle(2);
    issue(12'h123, 12'h456, 14'h2000, 14'h2000);
    drain();
    mode = 4'b0101;
    idle(1);
    issue(12'h000, 12'h000, 14'h2000, 14'h2000);
    issue(12'h000, 12'h000, 14'h2064, 14'h2064);
    drain();

    // Statistics
    mode     = 4'b0000;
    stat_clr = 1'b1;
    idle(1);
    stat_clr = 1'b0;
    issue(12'h005, 12'h005, 14'h2014, 14'h2014);
    issue(12'hFFD, 12'hFFD, 14'h1FF4, 14'h1FF4);
    issue(12'h064, 12'h064, 14'h2190, 14'h2190);
    issue(12'hF38, 12'hF38, 14'h1CE0, 14'h1CE0);
    drain();
    check("peak_max", peak_max, {12'h064, 12'h064});
    check("peak_min", peak_min, {12'hF38, 12'hF38});
    issue(12'h007, 12'h007, 14'h201C, 14'h201C);
    stat_clr = 1'b1;
    idle(1);
    stat_clr = 1'b0;
    check("clr_with_sample_max", peak_max, {12'h007, 12'h007});
    check("clr_with_sample_min", peak_min, {12'h007, 12'h007});
    drain();

    // Reset in the middle of a continuous DC stream
    mode     = 4'b1010;
    dc_value = {14'h1000, 14'h1000};
    idle(1);
    issue(12'h000, 12'h000, 14'h3000, 14'h3000);
    issue(12'h000, 12'h000, 14'h3000, 14'h3000);
    issue(12'h000, 12'h000, 14'h3000, 14'h3000);
    rst_n         = 1'b0;
    bus.sample_ce = 1'b1;
    @(posedge sys_clk);
    #1;
    rst_n = 1'b1;
    q.delete();
    check("midrst_dac_data", bus.dac_data, {14'h2000, 14'h2000});
    check("midrst_dac_valid", bus.dac_valid, 0);
    for (int k = 0; k < 4; k++) issue(12'h000, 12'h000, 14'h3000, 14'h3000);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout at cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

endmodule
